// File: rtl/ltc2333_sampler.sv
// ltc2333_sampler
//   Drives an LTC2333 8-channel 18-bit SAR ADC. It issues periodic CNV pulses,
//   reads back one 24-bit word per channel over SCK/SDO, and programs the next
//   conversion's sequence entry over SDI. Conversions are summed per channel
//   over a window of nsum samples, and each sum is emitted as a one-hot write
//   strobe burst for the downstream timestamp FIFO stage.
//
// Ports
//   clk            IP clock
//   aresetn_local  asynchronous active-low reset
//   enable         run conversions (level)
//   trig_period    clk cycles between CNV rising edges (0/1: back-to-back)
//   nsum           conversions summed per output (0 treated as 1)
//   softspan       3-bit SoftSpan code per channel, channel k at [3k+2:3k]
//   cnv            ADC CNV; downstream also uses it as the timestamp trigger
//   sck            ADC serial clock, idles low
//   sdi            ADC configuration data, MSB first
//   sdo            ADC serial data, sampled on the sck rising edge
//   ch_data        signed per-channel sum, valid while ch_we is non-zero
//   ch_we          one-hot write strobe, bit k = channel k
//   frame_err      sticky: a returned channel id did not match its slot
//   overrun        sticky: a start pulse arrived while a frame was in flight
//
// T_CONV must exceed CNV_HIGH so that the WAIT phase is at least one cycle.
module ltc2333_sampler #(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned SCK_DIV  = 2,
  parameter int unsigned CNV_HIGH = 4,
  parameter int unsigned T_CONV   = 60,
  parameter int unsigned SUM_W    = 32
) (
  input  logic             clk,
  input  logic             aresetn_local,
  input  logic             enable,
  input  logic [31:0]      trig_period,
  input  logic [15:0]      nsum,
  input  logic [23:0]      softspan,
  output logic             cnv,
  output logic             sck,
  output logic             sdi,
  input  logic             sdo,
  output logic [SUM_W-1:0] ch_data,
  output logic [7:0]       ch_we,
  output logic             frame_err,
  output logic             overrun
);

  localparam logic [15:0] CNV_LAST  = 16'(CNV_HIGH - 1);
  localparam logic [15:0] WAIT_LAST = 16'(T_CONV - CNV_HIGH - 1);
  localparam logic [15:0] PH_SAMP   = 16'(SCK_DIV - 1);
  localparam logic [15:0] PH_RISE   = 16'(SCK_DIV);
  localparam logic [15:0] PH_LAST   = 16'(2 * SCK_DIV - 1);
  localparam logic [2:0]  CH_LAST   = 3'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV,
    S_WAIT,
    S_SHIFT,
    S_ACC,
    S_EMIT
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      per_q, per_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [4:0]       bpos_q, bpos_d;
  logic [2:0]       slot_q, slot_d;
  logic [22:0]      sh_q, sh_d;
  logic [17:0]      frm_q [N_CH];
  logic [17:0]      frm_d [N_CH];
  logic             iderr_q, iderr_d;
  logic [SUM_W-1:0] acc_q [N_CH];
  logic [SUM_W-1:0] acc_d [N_CH];
  logic [23:0]      span_q, span_d;
  logic             cnv_q, cnv_d;
  logic             sck_q, sck_d;
  logic             sdi_q, sdi_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             short_per;
  logic             per_wrap;
  logic             start;
  logic [16:0]      cnt_inc;
  logic [15:0]      nsum_eff;
  logic [2:0]       span_sel;
  logic [23:0]      cfg_word;

  // Period counter and start pulse. A period of 0 or 1 degenerates into
  // "start whenever the FSM is idle", so it never reports an overrun.
  always_comb begin
    short_per = (trig_period <= 32'd1);
    per_wrap  = short_per || (per_q >= trig_period - 32'd1);
    start     = enable && per_wrap && (!short_per || (state_q == S_IDLE));
    if (!enable) begin
      per_d = '0;
    end else if (per_wrap) begin
      per_d = '0;
    end else begin
      per_d = per_q + 32'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bpos_d      = bpos_q;
    slot_d      = slot_q;
    sh_d        = sh_q;
    frm_d       = frm_q;
    iderr_d     = iderr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    span_d      = span_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q | (start && (state_q != S_IDLE));
    cnt_inc     = 17'(cnt_q) + 17'd1;
    nsum_eff    = (nsum == 16'd0) ? 16'd1 : nsum;

    case (state_q)
      S_IDLE: begin
        // Leaving enable low abandons the current window entirely, so the
        // partial sums go with the sample count.
        if (!enable) begin
          cnt_d = '0;
          for (int unsigned k = 0; k < N_CH; k++) begin
            acc_d[k] = '0;
          end
        end
        if (start) begin
          state_d = S_CNV;
          tmr_d   = '0;
          span_d  = softspan;
          iderr_d = 1'b0;
        end
      end

      S_CNV: begin
        if (tmr_q == CNV_LAST) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end

      S_WAIT: begin
        if (tmr_q == WAIT_LAST) begin
          state_d = S_SHIFT;
          tmr_d   = '0;
          bpos_d  = 5'd23;
          slot_d  = '0;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end

      S_SHIFT: begin
        // tmr_q is the sck phase; sdo is captured on the clk edge that
        // raises sck, i.e. while sdo still holds the bit set on the last fall.
        if (tmr_q == PH_SAMP) begin
          sh_d = {sh_q[21:0], sdo};
          if (bpos_q == 5'd0) begin
            frm_d[slot_q] = sh_q[22:5];
            if (sh_q[4:2] != slot_q) begin
              iderr_d = 1'b1;
            end
          end
        end
        if (tmr_q == PH_LAST) begin
          tmr_d = '0;
          if (bpos_q == 5'd0) begin
            bpos_d = 5'd23;
            if (slot_q == CH_LAST) begin
              state_d = S_ACC;
              slot_d  = '0;
            end else begin
              slot_d = slot_q + 3'd1;
            end
          end else begin
            bpos_d = bpos_q - 5'd1;
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end

      S_ACC: begin
        for (int unsigned k = 0; k < N_CH; k++) begin
          acc_d[k] = acc_q[k] + {{(SUM_W-18){frm_q[k][17]}}, frm_q[k]};
        end
        frame_err_d = frame_err_q | iderr_q;
        cnt_d       = cnt_inc[15:0];
        // >= so that lowering nsum mid-window emits immediately.
        if (cnt_inc >= {1'b0, nsum_eff}) begin
          state_d = S_EMIT;
          slot_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_EMIT: begin
        if (slot_q == CH_LAST) begin
          state_d = S_IDLE;
          slot_d  = '0;
          cnt_d   = '0;
          for (int unsigned k = 0; k < N_CH; k++) begin
            acc_d[k] = '0;
          end
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin outputs are registered from the next state so they change cleanly
    // on a clk edge; sdi therefore moves together with the sck falling edge.
    span_sel = 3'(span_q >> (5'd3 * 5'(slot_d)));
    cfg_word = {1'b1, slot_d, span_sel, 17'b0};
    cnv_d    = (state_d == S_CNV);
    sck_d    = (state_d == S_SHIFT) && (tmr_d >= PH_RISE);
    sdi_d    = (state_d == S_SHIFT) ? cfg_word[bpos_d] : 1'b0;
  end

  always_ff @(posedge clk or negedge aresetn_local) begin
    if (!aresetn_local) begin
      state_q     <= S_IDLE;
      per_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      bpos_q      <= '0;
      slot_q      <= '0;
      sh_q        <= '0;
      iderr_q     <= 1'b0;
      span_q      <= '0;
      cnv_q       <= 1'b0;
      sck_q       <= 1'b0;
      sdi_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        frm_q[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      bpos_q      <= bpos_d;
      slot_q      <= slot_d;
      sh_q        <= sh_d;
      iderr_q     <= iderr_d;
      span_q      <= span_d;
      cnv_q       <= cnv_d;
      sck_q       <= sck_d;
      sdi_q       <= sdi_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      frm_q       <= frm_d;
      acc_q       <= acc_d;
    end
  end

  assign cnv       = cnv_q;
  assign sck       = sck_q;
  assign sdi       = sdi_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign ch_data   = (state_q == S_EMIT) ? acc_q[slot_q] : '0;
  assign ch_we     = (state_q == S_EMIT) ? (8'd1 << slot_q) : '0;

endmodule
